// File: rtl/gci_std_kmc_scancode_decoder.sv
// PS/2 scancode set 2 decoder: folds E0/F0/E1 prefixes into one event per key
// action, tracks modifier keys and queues events in a first-word-fall-through
// FIFO read through a valid/ready handshake.
module gci_std_kmc_scancode_decoder #(
    parameter int unsigned P_FIFO_DEPTH   = 16,
    parameter int unsigned P_FIFO_DEPTH_N = 4,
    parameter int unsigned P_TIMEOUT      = 100000,
    parameter int unsigned P_TIMEOUT_N    = 17
) (
    input  logic                      iCLOCK,
    input  logic                      iRESET_SYNC,
    input  logic                      iPS2MOD_REQ,
    input  logic [7:0]                iPS2MOD_DATA,
    output logic                      oEVENT_VALID,
    input  logic                      iEVENT_READY,
    output logic [10:0]               oEVENT_DATA,
    output logic [P_FIFO_DEPTH_N:0]   oEVENT_COUNT,
    output logic [7:0]                oMODIFIER,
    output logic                      oOVERFLOW,
    input  logic                      iOVERFLOW_CLR,
    output logic                      oERROR
);

    typedef enum logic [2:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk,
        StPause
    } state_e;

    localparam logic [P_TIMEOUT_N-1:0]    TmoLast   = P_TIMEOUT_N'(P_TIMEOUT - 1);
    localparam logic [P_FIFO_DEPTH_N:0]   CountFull = (P_FIFO_DEPTH_N + 1)'(P_FIFO_DEPTH);
    // Pause sequence is E1 plus seven further bytes; the last one has index 6.
    localparam logic [2:0]                SkipLast  = 3'd6;

    // Decoder state
    state_e                   state_q, state_d;
    logic [2:0]               skip_q, skip_d;
    logic [P_TIMEOUT_N-1:0]   tmo_q, tmo_d;
    logic                     err_q, err_d;
    logic                     emit;
    logic [10:0]              emit_data;
    logic                     is_prefix;

    // Modifier state
    logic [7:0]               mod_q, mod_d;
    logic                     mod_hit;
    logic [2:0]               mod_idx;

    // FIFO state
    logic [10:0]              mem_q [P_FIFO_DEPTH];
    logic [P_FIFO_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
    logic [P_FIFO_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
    logic [P_FIFO_DEPTH_N:0]  count_q, count_d;
    logic                     ovf_q, ovf_d;
    logic                     full;
    logic                     rd_en;
    logic                     wr_en;
    logic                     ovf_set;

    assign is_prefix = (iPS2MOD_DATA == 8'hE0) || (iPS2MOD_DATA == 8'hF0) ||
                       (iPS2MOD_DATA == 8'hE1);

    // Decoder FSM next state, event emission, error pulse and sequence timeout
    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        tmo_d     = tmo_q;
        err_d     = 1'b0;
        emit      = 1'b0;
        emit_data = '0;
        if (iPS2MOD_REQ) begin
            tmo_d = '0;
            case (state_q)
                StIdle: begin
                    case (iPS2MOD_DATA)
                        8'hE0: state_d = StExt;
                        8'hF0: state_d = StBrk;
                        8'hE1: begin
                            state_d = StPause;
                            skip_d  = '0;
                        end
                        // Keyboard status/ack bytes carry no key information.
                        8'hFA, 8'hAA, 8'hEE, 8'hFE: state_d = StIdle;
                        8'h00, 8'hFF: err_d = 1'b1;
                        default: begin
                            emit      = 1'b1;
                            emit_data = {3'b000, iPS2MOD_DATA};
                        end
                    endcase
                end
                StExt: begin
                    if (iPS2MOD_DATA == 8'hF0) begin
                        state_d = StExtBrk;
                    end else if (iPS2MOD_DATA == 8'hE0) begin
                        state_d = StExt;
                    end else begin
                        emit      = 1'b1;
                        emit_data = {3'b001, iPS2MOD_DATA};
                        state_d   = StIdle;
                    end
                end
                StBrk, StExtBrk: begin
                    if (is_prefix) begin
                        // Broken sequence: flag it, then treat the prefix as a fresh start.
                        err_d = 1'b1;
                        case (iPS2MOD_DATA)
                            8'hE0:   state_d = StExt;
                            8'hF0:   state_d = StBrk;
                            default: begin
                                state_d = StPause;
                                skip_d  = '0;
                            end
                        endcase
                    end else begin
                        emit      = 1'b1;
                        emit_data = {2'b01, (state_q == StExtBrk), iPS2MOD_DATA};
                        state_d   = StIdle;
                    end
                end
                StPause: begin
                    if (skip_q == SkipLast) begin
                        emit      = 1'b1;
                        emit_data = 11'h400;
                        state_d   = StIdle;
                    end else begin
                        skip_d = skip_q + 3'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            if (tmo_q == TmoLast) begin
                state_d = StIdle;
                tmo_d   = '0;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // Modifier tracking: make sets, break clears, independent of FIFO acceptance
    always_comb begin
        mod_d   = mod_q;
        mod_hit = 1'b1;
        mod_idx = '0;
        case ({emit_data[8], emit_data[7:0]})
            9'h012:  mod_idx = 3'd0;
            9'h014:  mod_idx = 3'd1;
            9'h011:  mod_idx = 3'd2;
            9'h11F:  mod_idx = 3'd3;
            9'h059:  mod_idx = 3'd4;
            9'h114:  mod_idx = 3'd5;
            9'h111:  mod_idx = 3'd6;
            9'h127:  mod_idx = 3'd7;
            default: mod_hit = 1'b0;
        endcase
        if (emit && !emit_data[10] && mod_hit) begin
            mod_d[mod_idx] = !emit_data[9];
        end
    end

    assign full    = (count_q == CountFull);
    assign rd_en   = oEVENT_VALID && iEVENT_READY;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en   = emit && (!full || rd_en);
    assign ovf_set = emit && full && !rd_en;

    // FIFO pointer, occupancy and sticky overflow next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (iOVERFLOW_CLR) begin
            ovf_d = 1'b0;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q  <= StIdle;
            skip_q   <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            mod_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            skip_q   <= skip_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            mod_q    <= mod_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Event storage; contents need no reset because the head is masked when empty
    always_ff @(posedge iCLOCK) begin
        if (wr_en && !iRESET_SYNC) begin
            mem_q[wr_ptr_q] <= emit_data;
        end
    end

    assign oEVENT_VALID = (count_q != '0);
    assign oEVENT_DATA  = oEVENT_VALID ? mem_q[rd_ptr_q] : 11'h000;
    assign oEVENT_COUNT = count_q;
    assign oMODIFIER    = mod_q;
    assign oOVERFLOW    = ovf_q;
    assign oERROR       = err_q;

endmodule
